// File: rtl/freq_divider.sv
// Clock-enable generator: emits a one-cycle strobe on pulse_out every
// INPUT_FREQ/OUTPUT_FREQ cycles of clk (truncated ratio, no fractional carry).
module freq_divider #(
  parameter int INPUT_FREQ  = 27_000_000,
  parameter int OUTPUT_FREQ = 1_000
) (
  input  logic clk,
  input  logic n_reset,
  output logic pulse_out
);

  // Guarded so a bad OUTPUT_FREQ reaches the fatal check below instead of a divide-by-zero.
  localparam int DIVIDER = (OUTPUT_FREQ > 0) ? (INPUT_FREQ / OUTPUT_FREQ) : 1;
  localparam int CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIVIDER - 1);

  if (INPUT_FREQ <= 0) begin : g_chk_input_freq
    $fatal(1, "freq_divider: INPUT_FREQ must be positive");
  end

  if (OUTPUT_FREQ <= 0) begin : g_chk_output_freq
    $fatal(1, "freq_divider: OUTPUT_FREQ must be positive");
  end

  if (OUTPUT_FREQ > INPUT_FREQ) begin : g_chk_ratio
    $fatal(1, "freq_divider: OUTPUT_FREQ must not exceed INPUT_FREQ");
  end

  logic [CNT_W-1:0] counter;

  // Counter only ever walks 0..DIVIDER-1, so no overflow path is needed.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      counter   <= '0;
      pulse_out <= 1'b0;
    end else if (counter == TERMINAL) begin
      counter   <= '0;
      pulse_out <= 1'b1;
    end else begin
      counter   <= counter + CNT_W'(1);
      pulse_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_divider.sv
// Directed bench for freq_divider: default (27 MHz -> 1 kHz), DIVIDER=3 and
// DIVIDER=1 instances share one clock and reset.
`timescale 1ns/1ps
module tb_freq_divider;

  logic clk;
  logic n_reset;
  logic pulse_d, pulse_3, pulse_1;

  int n_checks = 0;
  int n_fail   = 0;

  freq_divider dut_d (
    .clk       (clk),
    .n_reset   (n_reset),
    .pulse_out (pulse_d)
  );

  freq_divider #(.INPUT_FREQ(10), .OUTPUT_FREQ(3)) dut_3 (
    .clk       (clk),
    .n_reset   (n_reset),
    .pulse_out (pulse_3)
  );

  freq_divider #(.INPUT_FREQ(1000), .OUTPUT_FREQ(1000)) dut_1 (
    .clk       (clk),
    .n_reset   (n_reset),
    .pulse_out (pulse_1)
  );

  initial clk = 1'b0;
  always #18.5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic n_reset;
    int   cnt3;
    logic p3;
    int   cnt1;
    logic p1;
    int   cntd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int k;
    int pulses;
    int first_edge;
    int last_edge;
    int div_val;
    bit found;

    // Per-edge expectations after reset release (edge index starts at 1).
    vecs[0]  = '{1'b1, 1, 1'b0, 0, 1'b1, 1};
    vecs[1]  = '{1'b1, 2, 1'b0, 0, 1'b1, 2};
    vecs[2]  = '{1'b1, 0, 1'b1, 0, 1'b1, 3};
    vecs[3]  = '{1'b1, 1, 1'b0, 0, 1'b1, 4};
    vecs[4]  = '{1'b1, 2, 1'b0, 0, 1'b1, 5};
    vecs[5]  = '{1'b1, 0, 1'b1, 0, 1'b1, 6};
    vecs[6]  = '{1'b0, 0, 1'b0, 0, 1'b0, 0};
    vecs[7]  = '{1'b0, 0, 1'b0, 0, 1'b0, 0};
    vecs[8]  = '{1'b1, 1, 1'b0, 0, 1'b1, 1};
    vecs[9]  = '{1'b1, 2, 1'b0, 0, 1'b1, 2};
    vecs[10] = '{1'b1, 0, 1'b1, 0, 1'b1, 3};

    n_reset = 1'b0;

    // Reset held across several edges (~111 ns).
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_cnt_d", int'(dut_d.counter), 0);
      check("rst_hold_pulse_d", int'(pulse_d), 0);
      check("rst_hold_pulse_1", int'(pulse_1), 0);
    end

    div_val = dut_d.DIVIDER;
    check("divider_default", div_val, 27000);
    check("cnt_w_default", $bits(dut_d.counter), 15);

    for (int i = 0; i < 11; i++) begin
      n_reset = vecs[i].n_reset;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_cnt3", i), int'(dut_3.counter), vecs[i].cnt3);
      check($sformatf("vec%0d_pulse3", i), int'(pulse_3), int'(vecs[i].p3));
      check($sformatf("vec%0d_cnt1", i), int'(dut_1.counter), vecs[i].cnt1);
      check($sformatf("vec%0d_pulse1", i), int'(pulse_1), int'(vecs[i].p1));
      check($sformatf("vec%0d_cntd", i), int'(dut_d.counter), vecs[i].cntd);
      check($sformatf("vec%0d_pulsed", i), int'(pulse_d), 0);
      @(negedge clk);
    end

    // Async reset in the middle of a count, with no clock edge in between.
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (dut_d.counter == 15'd5000) found = 1;
    end
    check("midcount_reached_5000", int'(found), 1);
    #5;
    n_reset = 1'b0;
    #1;
    check("midcount_rst_cnt_d", int'(dut_d.counter), 0);
    check("midcount_rst_pulse_d", int'(pulse_d), 0);
    check("midcount_rst_pulse_1", int'(pulse_1), 0);
    @(negedge clk);
    @(negedge clk);
    check("midcount_rst_still_held", int'(dut_d.counter), 0);

    // 3 ms run: 3 x 27000 edges plus a small tail.
    n_reset = 1'b1;
    pulses = 0;
    first_edge = -1;
    last_edge = -1;
    for (k = 1; k <= 81005; k++) begin
      @(posedge clk);
      #1;
      if (pulse_d) begin
        if (pulses == 0) first_edge = k;
        else check("pulse_spacing", k - last_edge, 27000);
        last_edge = k;
        pulses++;
      end
      if (k <= 81000) begin
        if (k % 27000 == 26999) begin
          check("cnt_before_pulse", int'(dut_d.counter), 26999);
          check("no_pulse_before", int'(pulse_d), 0);
        end else if (k % 27000 == 0) begin
          check("cnt_on_pulse", int'(dut_d.counter), 0);
          check("pulse_on_edge", int'(pulse_d), 1);
        end else if (k % 27000 == 1 && k > 1) begin
          check("pulse_width_one", int'(pulse_d), 0);
          check("cnt_after_pulse", int'(dut_d.counter), 1);
        end
      end
    end
    check("pulse_count_3ms", pulses, 3);
    check("first_pulse_edge", first_edge, 27000);
    check("last_pulse_edge", last_edge, 81000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
